stopwatch_seq: RTL and testbench

Sequencing controller for a chain of synchronous decade (BCD) counter digits. It runs a start/stop/clear/lap state machine and a prescaler that produces the count tick. It owns a DIGITS-wide cascaded decade counter with synchronous carries, replacing ripple-clocked decade stages. It sits between push-button style command inputs and a display driver.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 29 ++
 rtl/stopwatch_seq.sv | 144 ++++++++++++++
 tb/tb_stopwatch_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer.
//   state_t     : FSM state encoding
//   BCD_W       : bits per decade digit
//   BCD_MAX     : highest legal digit value
//   presc_width : bits needed to hold a prescaler phase (0..PRESCALE-1)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // ceil(log2(p)), never less than 1 so a PRESCALE of 1 still gets a bit
    function automatic int presc_width(input int p);
        int w;
        w = 1;
        while ((1 << w) < p) w++;
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One synchronous decade digit.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear to 0
//   en    : advance by one (9 wraps to 0)
//   q     : digit value, always 0..9
//   carry : en while at 9, i.e. the next digit should advance
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

    assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: start/stop/clear/lap FSM, count-tick prescaler and a
// DIGITS-wide cascaded BCD counter with synchronous carries.
//   clk, reset                 : clock, synchronous active-high reset
//   start, stop, clear         : level commands (priority clear > stop > start)
//   lap                        : display freeze toggle, edge-detected, RUN only
//   count                      : live BCD count, digit 0 in bits [3:0]
//   display                    : count, or the frozen lap value while lap_hold
//   running, lap_hold          : status
//   overflow                   : sticky all-9s rollover flag
//   tick                       : prescaler terminal phase while in RUN
//
// state  | meaning
// IDLE   | zeroed, waiting for start
// RUN    | prescaler running, count advancing on tick
// PAUSE  | count and prescaler phase frozen, start resumes
// HALT   | saturated at all-9s, only clear/reset leaves
module stopwatch_seq
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic [BCD_W*DIGITS-1:0] display,
    output logic                    running,
    output logic                    lap_hold,
    output logic                    overflow,
    output logic                    tick
);

    localparam int             PW       = presc_width(PRESCALE);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    state_t                    state_q;
    logic [PW-1:0]             presc_q;
    logic [BCD_W*DIGITS-1:0]   frz_q;
    logic                      lap_hold_q;
    logic                      ovf_q;
    logic                      lap_prev_q;

    logic                      all_nines;
    logic                      adv_raw;
    logic                      sat_evt;
    logic                      wrap_evt;
    logic                      lap_rise;
    logic [DIGITS-1:0]         en_chain;

    assign tick     = (state_q == ST_RUN) && (presc_q == PRE_LAST);
    // stop and clear both outrank the tick
    assign adv_raw  = tick && !stop && !clear;
    assign sat_evt  = adv_raw && all_nines && (SATURATE != 0);
    assign lap_rise = lap && !lap_prev_q;

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[i*BCD_W +: BCD_W] != BCD_MAX) all_nines = 1'b0;
        end
    end

    // In saturating mode the chain is never enabled at all-9s, so the count
    // holds; otherwise the top digit's carry marks the wrap to all-0s.
    assign en_chain[0] = adv_raw && !sat_evt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic carry_i;
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clear),
            .en    (en_chain[i]),
            .q     (count[i*BCD_W +: BCD_W]),
            .carry (carry_i)
        );
        if (i < DIGITS - 1) begin : g_link
            assign en_chain[i+1] = carry_i;
        end else begin : g_top
            assign wrap_evt = carry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            frz_q      <= '0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
            lap_prev_q <= 1'b0;
        end else begin
            lap_prev_q <= lap;
            if (clear) begin
                state_q    <= ST_IDLE;
                presc_q    <= '0;
                lap_hold_q <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!stop && start) begin
                            state_q <= ST_RUN;
                            presc_q <= '0;
                        end
                    end
                    ST_PAUSE: begin
                        if (!stop && start) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_q <= ST_PAUSE;
                        end else begin
                            presc_q <= (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
                            if (sat_evt || wrap_evt) ovf_q <= 1'b1;
                            if (sat_evt) state_q <= ST_HALT;
                            // an asserted start, though a no-op, still masks lap
                            if (!start && lap_rise) begin
                                if (lap_hold_q) begin
                                    lap_hold_q <= 1'b0;
                                end else begin
                                    lap_hold_q <= 1'b1;
                                    frz_q      <= count;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign running  = (state_q == ST_RUN);
    assign lap_hold = lap_hold_q;
    assign overflow = ovf_q;
    assign display  = lap_hold_q ? frz_q : count;

endmodule

// File: tb/tb_stopwatch_seq.sv
module tb_stopwatch_seq;

    localparam int DIG = 2;
    localparam int PRE = 2;
    localparam int CMAX = 99;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

    logic [7:0] count_s, display_s, count_w, display_w;
    logic running_s, lap_hold_s, overflow_s, tick_s;
    logic running_w, lap_hold_w, overflow_w, tick_w;

    always #5 clk = ~clk;

    stopwatch_seq #(.DIGITS(DIG), .PRESCALE(PRE), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(count_s), .display(display_s), .running(running_s),
        .lap_hold(lap_hold_s), .overflow(overflow_s), .tick(tick_s)
    );

    stopwatch_seq #(.DIGITS(DIG), .PRESCALE(PRE), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(count_w), .display(display_w), .running(running_w),
        .lap_hold(lap_hold_w), .overflow(overflow_w), .tick(tick_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: index 0 saturating, 1 wrapping. Count kept as a plain
    // integer; mode 0 idle, 1 run, 2 pause, 3 halted.
    int m_mode[2], m_cnt[2], m_ph[2], m_frz[2];
    bit m_hold[2], m_ovf[2];
    bit m_lap_prev;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic model_step(input bit rs, input bit st, input bit sp, input bit cl, input bit lp);
        bit rise;
        rise = lp && !m_lap_prev;
        m_lap_prev = rs ? 1'b0 : lp;
        for (int k = 0; k < 2; k++) begin
            if (rs || cl) begin
                m_mode[k] = 0; m_cnt[k] = 0; m_ph[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
                if (rs) m_frz[k] = 0;
            end else if (sp) begin
                if (m_mode[k] == 1) m_mode[k] = 2;
            end else if (st && m_mode[k] != 1) begin
                if (m_mode[k] == 0) begin m_mode[k] = 1; m_ph[k] = 0; end
                else if (m_mode[k] == 2) m_mode[k] = 1;
            end else if (m_mode[k] == 1) begin
                if (!st && rise) begin
                    if (m_hold[k]) m_hold[k] = 0;
                    else begin m_hold[k] = 1; m_frz[k] = m_cnt[k]; end
                end
                if (m_ph[k] == PRE - 1) begin
                    m_ph[k] = 0;
                    if (m_cnt[k] == CMAX) begin
                        m_ovf[k] = 1;
                        if (k == 0) m_mode[k] = 3;
                        else m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    m_ph[k] = m_ph[k] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("s_count",    count_s,    to_bcd(m_cnt[0]));
        chk("s_display",  display_s,  to_bcd(m_hold[0] ? m_frz[0] : m_cnt[0]));
        chk("s_running",  running_s,  (m_mode[0] == 1));
        chk("s_lap_hold", lap_hold_s, m_hold[0]);
        chk("s_overflow", overflow_s, m_ovf[0]);
        chk("s_tick",     tick_s,     (m_mode[0] == 1 && m_ph[0] == PRE - 1));
        chk("w_count",    count_w,    to_bcd(m_cnt[1]));
        chk("w_display",  display_w,  to_bcd(m_hold[1] ? m_frz[1] : m_cnt[1]));
        chk("w_running",  running_w,  (m_mode[1] == 1));
        chk("w_lap_hold", lap_hold_w, m_hold[1]);
        chk("w_overflow", overflow_w, m_ovf[1]);
        chk("w_tick",     tick_w,     (m_mode[1] == 1 && m_ph[1] == PRE - 1));
    endtask

    task automatic cyc(input bit rs, input bit st, input bit sp, input bit cl, input bit lp);
        reset = rs; start = st; stop = sp; clear = cl; lap = lp;
        @(posedge clk);
        model_step(rs, st, sp, cl, lp);
        #1;
        compare_all();
    endtask

    task automatic run_until(input int target, input int maxc);
        int n;
        n = 0;
        while (m_cnt[0] != target && n < maxc) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("wait_count", m_cnt[0], target);
    endtask

    initial begin
        int n;
        m_lap_prev = 0;
        // reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_count", count_s, 8'h00);
        chk("rst_running", running_s, 1'b0);

        // start latency and first decade carry
        cyc(0, 1, 0, 0, 0);
        chk("start_running", running_s, 1'b1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("first_tick", count_s, 8'h01);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, 0);
        chk("carry10", count_s, 8'h10);

        // rollover in both modes
        run_until(CMAX, 400);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_hold", count_s, 8'h99);
        chk("sat_ovf", overflow_s, 1'b1);
        chk("sat_stopped", running_s, 1'b0);
        chk("wrap_zero", count_w, 8'h00);
        chk("wrap_ovf", overflow_w, 1'b1);
        chk("wrap_running", running_w, 1'b1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_continue", count_w, 8'h01);
        cyc(0, 1, 0, 0, 0);
        chk("halt_start_ignored", running_s, 1'b0);
        cyc(0, 0, 0, 1, 0);
        chk("clear_count", count_s, 8'h00);
        chk("clear_ovf", overflow_s, 1'b0);

        // lap freeze and release
        cyc(0, 1, 0, 0, 0);
        run_until(23, 100);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        run_until(30, 100);
        chk("lap_frozen", display_s, 8'h23);
        cyc(0, 0, 0, 0, 1);
        chk("lap_release", display_s, count_s);

        // stop on a tick cycle, resume
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        n = 0;
        while (!(m_cnt[0] == 5 && m_ph[0] == 1) && n < 100) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("wait_stop_point", n < 100, 1'b1);
        cyc(0, 0, 1, 0, 0);
        chk("stop_on_tick", count_s, 8'h05);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("resume_tick", tick_s, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk("resume_count", count_s, 8'h06);

        // clear outranks stop and start; reset mid-run
        run_until(42, 200);
        cyc(0, 1, 1, 1, 0);
        chk("combo_clear", count_s, 8'h00);
        chk("combo_idle", running_s, 1'b0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("midrun_reset", {count_s, running_s, overflow_s, lap_hold_s}, 11'd0);

        // random command soup
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 4),
                ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 99) < 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
